// File: rtl/stream_offs_uloop_if.sv
// ---------------------------------------------------------------------------
// stream_offs_uloop_if
// Micro-loop handshake between the controlling FSM (master) and the offset
// generator (slave): enable/clear/ready plus loop configuration going in,
// valid/done/offsets/indices coming back.
// ---------------------------------------------------------------------------
interface stream_offs_uloop_if #(
    parameter int unsigned NB_LOOPS   = 3,
    parameter int unsigned NB_OFFS    = 3,
    parameter int unsigned OFFS_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                                   clear_i;
    logic                                   enable_i;
    logic                                   ready_i;
    logic [NB_LOOPS*CNT_WIDTH-1:0]          loop_len_i;
    logic [NB_LOOPS*NB_OFFS*OFFS_WIDTH-1:0] stride_i;
    logic                                   valid_o;
    logic                                   done_o;
    logic [NB_OFFS*OFFS_WIDTH-1:0]          offs_o;
    logic [NB_LOOPS*CNT_WIDTH-1:0]          idx_o;

    // Controlling FSM side
    modport master (
        output clear_i, enable_i, ready_i, loop_len_i, stride_i,
        input  valid_o, done_o, offs_o, idx_o
    );

    // Offset generator side
    modport slave (
        input  clear_i, enable_i, ready_i, loop_len_i, stride_i,
        output valid_o, done_o, offs_o, idx_o
    );
endinterface

// File: rtl/stream_offs_uloop.sv
// ---------------------------------------------------------------------------
// stream_offs_uloop
// Walks NB_LOOPS nested loops (index 0 innermost) and produces one byte offset
// per stream. Each loop keeps a per-stream base register so an advance of loop
// k is a single add: new = base[k] + stride[k]; all inner bases reload with it.
//
// Optional build macro ULOOP_DONE_STICKY_EN: done_o stays high after the
// wrapping update until clear/reset, and enables are ignored meanwhile.
// ---------------------------------------------------------------------------
module stream_offs_uloop #(
    parameter int unsigned NB_LOOPS   = 3,
    parameter int unsigned NB_OFFS    = 3,
    parameter int unsigned OFFS_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    stream_offs_uloop_if.slave   uloop
);

    typedef enum logic {
        IDLE,
        UPDATE
    } state_e;

    typedef logic [CNT_WIDTH-1:0]  cnt_t;
    typedef logic [OFFS_WIDTH-1:0] offs_t;

    state_e state_q;
    logic   valid_q;
    logic   done_q;
    cnt_t   idx_q  [NB_LOOPS];
    offs_t  base_q [NB_LOOPS][NB_OFFS];
    offs_t  offs_q [NB_OFFS];

    cnt_t   idx_d  [NB_LOOPS];
    offs_t  base_d [NB_LOOPS][NB_OFFS];
    offs_t  offs_d [NB_OFFS];
    logic   wrap_d;

    cnt_t   loop_len [NB_LOOPS];
    cnt_t   last_idx [NB_LOOPS];
    logic   at_last  [NB_LOOPS];
    offs_t  stride   [NB_LOOPS][NB_OFFS];
    offs_t  new_offs [NB_OFFS];
    logic   accept;
    logic   block_en;

    // Unpack the flat configuration buses into per-loop / per-stream views
    for (genvar l = 0; l < NB_LOOPS; l++) begin : g_unpack_loop
        assign loop_len[l] = uloop.loop_len_i[l*CNT_WIDTH +: CNT_WIDTH];
        // A length of 0 behaves as a single-iteration loop
        assign last_idx[l] = (loop_len[l] == '0) ? '0 : loop_len[l] - 1'b1;
        // >= rather than == so a length shrunk mid-run still carries out
        // instead of counting all the way around the counter width
        assign at_last[l]  = (idx_q[l] >= last_idx[l]);
        for (genvar o = 0; o < NB_OFFS; o++) begin : g_unpack_offs
            assign stride[l][o] =
                uloop.stride_i[(l*NB_OFFS + o)*OFFS_WIDTH +: OFFS_WIDTH];
        end
    end

`ifdef ULOOP_DONE_STICKY_EN
    // Once wrapped, the block stays parked until clear/reset
    assign block_en = done_q;
`else
    assign block_en = 1'b0;
`endif

    assign accept = uloop.enable_i & uloop.ready_i & ~block_en;

    // Carry chain: find the lowest loop not at its last index and build the
    // complete next index/base/offset set for one update
    always_comb begin
        int   k;
        logic carry;
        // NOTE: every always_comb target gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        k     = 0;
        carry = 1'b1;
        for (int l = 0; l < NB_LOOPS; l++) begin
            idx_d[l] = idx_q[l];
            if (carry) begin
                if (at_last[l]) begin
                    idx_d[l] = '0;
                end else begin
                    idx_d[l] = idx_q[l] + 1'b1;
                    k        = l;
                    carry    = 1'b0;
                end
            end
        end
        wrap_d = carry;

        for (int o = 0; o < NB_OFFS; o++) begin
            new_offs[o] = '0;
            for (int l = 0; l < NB_LOOPS; l++) begin
                if (l == k) new_offs[o] = base_q[l][o] + stride[l][o];
            end
            offs_d[o] = wrap_d ? '0 : new_offs[o];
        end

        for (int l = 0; l < NB_LOOPS; l++) begin
            for (int o = 0; o < NB_OFFS; o++) begin
                if (wrap_d)      base_d[l][o] = '0;
                else if (l <= k) base_d[l][o] = new_offs[o];
                else             base_d[l][o] = base_q[l][o];
            end
        end
    end

    // Control FSM with registered outputs; counters, bases and offsets only
    // load on the accept edge so they appear together with valid_o
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the base/index arrays are state the carry rule reads back,
            // so every element is reset, not just the control flops.
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int l = 0; l < NB_LOOPS; l++) begin
                idx_q[l] <= '0;
                for (int o = 0; o < NB_OFFS; o++) base_q[l][o] <= '0;
            end
            for (int o = 0; o < NB_OFFS; o++) offs_q[o] <= '0;
        end else if (uloop.clear_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int l = 0; l < NB_LOOPS; l++) begin
                idx_q[l] <= '0;
                for (int o = 0; o < NB_OFFS; o++) base_q[l][o] <= '0;
            end
            for (int o = 0; o < NB_OFFS; o++) offs_q[o] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= UPDATE;
                        valid_q <= 1'b1;
                        done_q  <= wrap_d;
                        for (int l = 0; l < NB_LOOPS; l++) begin
                            idx_q[l] <= idx_d[l];
                            for (int o = 0; o < NB_OFFS; o++)
                                base_q[l][o] <= base_d[l][o];
                        end
                        for (int o = 0; o < NB_OFFS; o++) offs_q[o] <= offs_d[o];
                    end
                end
                UPDATE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
`ifndef ULOOP_DONE_STICKY_EN
                    done_q  <= 1'b0;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Drive the packed output buses from the registered state
    assign uloop.valid_o = valid_q;
    assign uloop.done_o  = done_q;
    for (genvar o = 0; o < NB_OFFS; o++) begin : g_pack_offs
        assign uloop.offs_o[o*OFFS_WIDTH +: OFFS_WIDTH] = offs_q[o];
    end
    for (genvar l = 0; l < NB_LOOPS; l++) begin : g_pack_idx
        assign uloop.idx_o[l*CNT_WIDTH +: CNT_WIDTH] = idx_q[l];
    end

endmodule

// File: tb/tb_stream_offs_uloop.sv
// ---------------------------------------------------------------------------
// tb_stream_offs_uloop
// Directed bench for stream_offs_uloop with hand-computed expected offsets.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_stream_offs_uloop;

    localparam int unsigned NL = 3;
    localparam int unsigned NO = 3;
    localparam int unsigned OW = 32;
    localparam int unsigned CW = 16;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    int checks = 0;
    int errors = 0;

    stream_offs_uloop_if #(
        .NB_LOOPS(NL), .NB_OFFS(NO), .OFFS_WIDTH(OW), .CNT_WIDTH(CW)
    ) uif ();

    stream_offs_uloop #(
        .NB_LOOPS(NL), .NB_OFFS(NO), .OFFS_WIDTH(OW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .uloop  (uif.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] offs_a();
        return uif.offs_o[31:0];
    endfunction

    function automatic logic [31:0] offs_b();
        return uif.offs_o[63:32];
    endfunction

    // Loop lengths and A/B strides for loops 0 and 1 (all other strides 0)
    task automatic set_cfg(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                           input logic [31:0] sa0, input logic [31:0] sa1,
                           input logic [31:0] sb0, input logic [31:0] sb1);
        logic [NL*NO*OW-1:0] s;
        s = '0;
        s[(0*NO+0)*OW +: OW] = sa0;
        s[(0*NO+1)*OW +: OW] = sb0;
        s[(1*NO+0)*OW +: OW] = sa1;
        s[(1*NO+1)*OW +: OW] = sb1;
        uif.stride_i   = s;
        uif.loop_len_i = {l2, l1, l0};
    endtask

    task automatic do_clear();
        uif.clear_i = 1'b1;
        @(negedge clk_i);
        uif.clear_i = 1'b0;
    endtask

    // One accepted update: valid one cycle after the accept, then back to idle
    task automatic do_upd(input string tag, input logic [31:0] ea, input logic ed);
        uif.enable_i = 1'b1;
        uif.ready_i  = 1'b1;
        @(negedge clk_i);
        uif.enable_i = 1'b0;
        check({tag, "_valid"}, 64'(uif.valid_o), 64'd1);
        check({tag, "_offsA"}, 64'(offs_a()), 64'(ea));
        check({tag, "_done"},  64'(uif.done_o), 64'(ed));
        @(negedge clk_i);
        check({tag, "_valid_drop"}, 64'(uif.valid_o), 64'd0);
    endtask

    initial begin
        int pulses, consec, dones, done_ok, bad;
        logic prev;

        uif.clear_i    = 1'b0;
        uif.enable_i   = 1'b0;
        uif.ready_i    = 1'b0;
        uif.loop_len_i = '0;
        uif.stride_i   = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_valid", 64'(uif.valid_o), 64'd0);
        check("rst_done",  64'(uif.done_o),  64'd0);
        check("rst_offs",  64'(uif.offs_o[63:0]), 64'd0);
        check("rst_idx",   64'(uif.idx_o),   64'd0);

        // 1: len {2,3,1}, A strides 16/64, B strides 1/10
        set_cfg(16'd2, 16'd3, 16'd1, 32'd16, 32'd64, 32'd1, 32'd10);
        do_clear();
        do_upd("t1_u1", 32'd16, 1'b0);
        check("t1_u1_offsB", 64'(offs_b()), 64'd1);
        check("t1_u1_idx",   64'(uif.idx_o), 64'h0000_0000_0001);
        do_upd("t1_u2", 32'd64, 1'b0);
        check("t1_u2_offsB", 64'(offs_b()), 64'd10);
        check("t1_u2_idx",   64'(uif.idx_o), 64'h0000_0001_0000);
        do_upd("t1_u3", 32'd80, 1'b0);
        check("t1_u3_offsB", 64'(offs_b()), 64'd11);
        do_upd("t1_u4", 32'd128, 1'b0);
        check("t1_u4_offsB", 64'(offs_b()), 64'd20);
        do_upd("t1_u5", 32'd144, 1'b0);
        check("t1_u5_idx",   64'(uif.idx_o), 64'h0000_0002_0001);
        do_upd("t1_u6", 32'd0, 1'b1);
        check("t1_u6_offsB", 64'(offs_b()), 64'd0);
        check("t1_u6_idx",   64'(uif.idx_o), 64'd0);

        // 2: enable held high -> pulse every other cycle, 6 to done
        do_clear();
        uif.enable_i = 1'b1;
        uif.ready_i  = 1'b1;
        pulses = 0; consec = 0; dones = 0; done_ok = 0; prev = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (uif.valid_o) begin
                pulses++;
                if (prev) consec++;
                if (uif.done_o) begin
                    dones++;
                    if (pulses == 6) done_ok = 1;
                end
            end
            prev = uif.valid_o;
        end
        uif.enable_i = 1'b0;
        check("t2_pulses",  64'(pulses),  64'd6);
        check("t2_consec",  64'(consec),  64'd0);
        check("t2_dones",   64'(dones),   64'd1);
        check("t2_done_6th", 64'(done_ok), 64'd1);

        // 3: enable without ready is dropped, not queued
        do_clear();
        uif.enable_i = 1'b1;
        uif.ready_i  = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (uif.valid_o) bad++;
        end
        check("t3_no_valid", 64'(bad), 64'd0);
        check("t3_offs_held", 64'(offs_a()), 64'd0);
        uif.ready_i = 1'b1;
        @(negedge clk_i);
        uif.enable_i = 1'b0;
        check("t3_valid", 64'(uif.valid_o), 64'd1);
        check("t3_offsA", 64'(offs_a()), 64'd16);
        @(negedge clk_i);
        check("t3_valid_drop", 64'(uif.valid_o), 64'd0);

        // 4: all lengths 0 -> single update that wraps immediately
        set_cfg(16'd0, 16'd0, 16'd0, 32'd16, 32'd64, 32'd1, 32'd10);
        do_clear();
        do_upd("t4", 32'd0, 1'b1);
`ifdef ULOOP_DONE_STICKY_EN
        check("t4_done_after", 64'(uif.done_o), 64'd1);
`else
        check("t4_done_after", 64'(uif.done_o), 64'd0);
`endif

        // 5: clear beats enable mid-run; async reset mid-update
        set_cfg(16'd2, 16'd3, 16'd1, 32'd16, 32'd64, 32'd1, 32'd10);
        do_clear();
        do_upd("t5_u1", 32'd16, 1'b0);
        do_upd("t5_u2", 32'd64, 1'b0);
        do_upd("t5_u3", 32'd80, 1'b0);
        uif.clear_i  = 1'b1;
        uif.enable_i = 1'b1;
        uif.ready_i  = 1'b1;
        @(negedge clk_i);
        uif.clear_i  = 1'b0;
        uif.enable_i = 1'b0;
        check("t5_clr_valid", 64'(uif.valid_o), 64'd0);
        check("t5_clr_offs",  64'(uif.offs_o[63:0]), 64'd0);
        check("t5_clr_idx",   64'(uif.idx_o), 64'd0);
        @(negedge clk_i);
        check("t5_clr_valid2", 64'(uif.valid_o), 64'd0);
        do_upd("t5_after_clr", 32'd16, 1'b0);
        do_upd("t5_u2b", 32'd64, 1'b0);
        uif.enable_i = 1'b1;
        @(negedge clk_i);
        uif.enable_i = 1'b0;
        check("t5_rst_pre_valid", 64'(uif.valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("t5_rst_valid", 64'(uif.valid_o), 64'd0);
        check("t5_rst_done",  64'(uif.done_o),  64'd0);
        check("t5_rst_offs",  64'(uif.offs_o[63:0]), 64'd0);
        check("t5_rst_idx",   64'(uif.idx_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_upd("t5_after_rst", 32'd16, 1'b0);

        // 6: negative stride wraps modulo 2^32
        set_cfg(16'd4, 16'd1, 16'd1, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0);
        do_clear();
        do_upd("t6_u1", 32'hFFFF_FFF0, 1'b0);
        do_upd("t6_u2", 32'hFFFF_FFE0, 1'b0);
        do_upd("t6_u3", 32'hFFFF_FFD0, 1'b0);
        do_upd("t6_u4", 32'd0, 1'b1);
`ifdef ULOOP_DONE_STICKY_EN
        uif.enable_i = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (uif.valid_o) bad++;
        end
        uif.enable_i = 1'b0;
        check("t6_sticky_novalid", 64'(bad), 64'd0);
        check("t6_sticky_done", 64'(uif.done_o), 64'd1);
        check("t6_sticky_offs", 64'(offs_a()), 64'd0);
`else
        do_upd("t6_restart", 32'hFFFF_FFF0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
